if_stage: RTL and testbench

- Instruction-fetch stage of the MIPS pipeline; sits directly upstream of the decode stage.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Presents the fetched instruction and its PC to decode through a registered IF/ID slot.
- Takes branch/jump redirects (jmp_flag/jmp_addr) back from decode and honours the MIPS single branch delay slot.

---
 rtl/if_stage.sv | 217 +++++++++++++++++++++
 tb/tb_if_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : MIPS instruction-fetch stage with single-outstanding imem port and
//            IF/ID slot; IF_ALIGN_CHECK_EN enables the misaligned-PC trap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jmp_flag,
    input  logic [31:0] jmp_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc,
    output logic        if_exc
);

`ifdef IF_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;
`endif

    state_t      state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic        imem_req_q, imem_req_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_ins_q,   id_ins_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] hold_q,     hold_d;
    logic        tgt_pend_q, tgt_pend_d;
    logic [31:0] tgt_q,      tgt_d;

    logic        slot_free;
    logic        consume;
    logic        load;
    logic [31:0] load_ins;
    logic [31:0] pc_inc;
    logic [31:0] next_pc;

`ifdef IF_ALIGN_CHECK_EN
    logic        if_exc_q, if_exc_d;
    logic        exc_load;
`endif

    assign slot_free = !id_valid_q || !stall;
    // A branch is sampled exactly once: when decode lets it leave the slot.
    assign consume   = id_valid_q && !stall && jmp_flag;
    assign pc_inc    = pc_q + 32'd4;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        load     = 1'b0;
        load_ins = NOP_INS;
`ifdef IF_ALIGN_CHECK_EN
        exc_load = 1'b0;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
`ifdef IF_ALIGN_CHECK_EN
                if (pc_q[1:0] != 2'b00) begin
                    if (slot_free) begin
                        exc_load = 1'b1;
                        state_d  = S_ERR;
                    end
                end else begin
                    state_d = S_WAIT;
                end
`else
                state_d = S_WAIT;
`endif
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (slot_free) begin
                        load     = 1'b1;
                        load_ins = imem_rdata;
                        state_d  = S_REQ;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    load     = 1'b1;
                    load_ins = hold_q;
                    state_d  = S_REQ;
                end
            end
`ifdef IF_ALIGN_CHECK_EN
            S_ERR: state_d = S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Every load is the delay slot whenever a target is pending, so the
    // pending target (or a same-cycle branch target) replaces pc+4 then.
    always_comb begin
        tgt_pend_d = tgt_pend_q;
        tgt_d      = tgt_q;
        next_pc    = pc_inc;
        if (load) begin
            if (tgt_pend_q) begin
                next_pc    = tgt_q;
                tgt_pend_d = 1'b0;
            end else if (consume) begin
                next_pc = jmp_addr;
            end
        end else if (consume) begin
            tgt_pend_d = 1'b1;
            tgt_d      = jmp_addr;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_ins_d   = id_ins_q;
        id_pc_d    = id_pc_q;
`ifdef IF_ALIGN_CHECK_EN
        if_exc_d   = if_exc_q;
`endif
        if (load) begin
            id_valid_d = 1'b1;
            id_ins_d   = load_ins;
            id_pc_d    = pc_q;
            pc_d       = next_pc;
`ifdef IF_ALIGN_CHECK_EN
        end else if (exc_load) begin
            id_valid_d = 1'b1;
            id_ins_d   = NOP_INS;
            id_pc_d    = pc_q;
            if_exc_d   = 1'b1;
`endif
        end else if (!stall) begin
            id_valid_d = 1'b0;
            id_ins_d   = NOP_INS;
        end
    end

    // Request is registered from the next state so it is high for the
    // whole REQ cycle and never for a misaligned address.
`ifdef IF_ALIGN_CHECK_EN
    assign imem_req_d = (state_d == S_REQ) && (pc_d[1:0] == 2'b00);
`else
    assign imem_req_d = (state_d == S_REQ);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            imem_req_q <= 1'b0;
            id_valid_q <= 1'b0;
            id_ins_q   <= NOP_INS;
            id_pc_q    <= 32'h0000_0000;
            hold_q     <= 32'h0000_0000;
            tgt_pend_q <= 1'b0;
            tgt_q      <= 32'h0000_0000;
`ifdef IF_ALIGN_CHECK_EN
            if_exc_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            imem_req_q <= imem_req_d;
            id_valid_q <= id_valid_d;
            id_ins_q   <= id_ins_d;
            id_pc_q    <= id_pc_d;
            hold_q     <= hold_d;
            tgt_pend_q <= tgt_pend_d;
            tgt_q      <= tgt_d;
`ifdef IF_ALIGN_CHECK_EN
            if_exc_q   <= if_exc_d;
`endif
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_ins    = id_ins_q;
    assign id_pc     = id_pc_q;
`ifdef IF_ALIGN_CHECK_EN
    assign if_exc    = if_exc_q;
`else
    assign if_exc    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage : directed + randomized bench for if_stage with memory and
//               program-flow reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INS  = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        jmp_flag;
    logic [31:0] jmp_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_ins;
    logic [31:0] id_pc;
    logic        if_exc;

    if_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INS  (NOP_INS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .jmp_flag    (jmp_flag),
        .jmp_addr    (jmp_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ins      (id_ins),
        .id_pc       (id_pc),
        .if_exc      (if_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;

    // memory model state
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_dly;
    int          fix_lat;
    bit          rand_lat;

    // program-flow reference model state
    logic [31:0] exp_pc;
    logic [31:0] tgt_m;
    bit          ds_flag;
    bit          prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_ins;
    int          n_del;
    int          idle_cnt;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h2001_0005;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: advance past the edge, then play the memory for this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            if (pend_dly == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(pend_addr);
                pend        = 1'b0;
            end else begin
                pend_dly--;
            end
        end
        if (imem_req) begin
            check1("single_outstanding", pend, 1'b0);
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_dly  = rand_lat ? int'($urandom_range(0, 2)) : fix_lat;
        end
    endtask

    task automatic next_valid(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) jmp_flag = 1'b0;
        end while (!id_valid && n < 20);
        check1({tag, "_valid"}, id_valid, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        check1 ({tag, "_req"},      imem_req,  1'b0);
        check32({tag, "_addr"},     imem_addr, RESET_PC);
        check1 ({tag, "_id_valid"}, id_valid,  1'b0);
        check32({tag, "_id_ins"},   id_ins,    NOP_INS);
        check32({tag, "_id_pc"},    id_pc,     32'h0);
        check1 ({tag, "_if_exc"},   if_exc,    1'b0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; jmp_flag = 1'b0; jmp_addr = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        pend = 1'b0; pend_addr = 32'h0; pend_dly = 0; fix_lat = 0; rand_lat = 1'b0;

        // ---- reset and first-fetch latency ----
        tick(); tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();
        check1 ("c2_req",  imem_req,  1'b1);
        check32("c2_addr", imem_addr, 32'h0);
        tick();
        tick();
        check1 ("c3_valid", id_valid,  1'b1);
        check32("c3_ins",   id_ins,    32'h2001_0005);
        check32("c3_pc",    id_pc,     32'h0);
        check32("c3_addr",  imem_addr, 32'h4);

        // ---- stall for 5 cycles while the response for 4 arrives ----
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check1 ("stall_valid", id_valid, 1'b1);
            check32("stall_pc",    id_pc,    32'h0);
            check32("stall_ins",   id_ins,   32'h2001_0005);
            check1 ("stall_req",   imem_req, 1'b0);
        end
        stall = 1'b0;
        tick();
        check32("unstall_pc",   id_pc,     32'h4);
        check32("unstall_ins",  id_ins,    memf(32'h4));
        check1 ("unstall_req",  imem_req,  1'b1);
        check32("unstall_addr", imem_addr, 32'h8);

        // ---- branch at 0x10 -> 0x100 with delay slot 0x14 ----
        next_valid("d8");  check32("d8_pc",  id_pc, 32'h8);
        next_valid("dC");  check32("dC_pc",  id_pc, 32'hC);
        next_valid("d10"); check32("d10_pc", id_pc, 32'h10);
        jmp_flag = 1'b1; jmp_addr = 32'h100;
        next_valid("ds14");
        check32("ds14_pc",   id_pc,     32'h14);
        check32("ds14_ins",  id_ins,    memf(32'h14));
        check1 ("ds14_req",  imem_req,  1'b1);
        check32("ds14_addr", imem_addr, 32'h100);
        next_valid("t100"); check32("t100_pc", id_pc, 32'h100);
        jmp_flag = 1'b1; jmp_addr = 32'h20;
        next_valid("ds104");
        check32("ds104_pc",   id_pc,     32'h104);
        check32("ds104_addr", imem_addr, 32'h20);
        next_valid("t20"); check32("t20_pc", id_pc, 32'h20);

        // ---- same-cycle: delay slot lands as branch at 0x20 is consumed ----
        stall = 1'b1;
        tick();
        check1("sc_rvalid_seen", imem_rvalid, 1'b1);
        stall = 1'b0; jmp_flag = 1'b1; jmp_addr = 32'h80; fix_lat = 2;
        tick();
        jmp_flag = 1'b0;
        check32("sc_pc",   id_pc,     32'h24);
        check1 ("sc_req",  imem_req,  1'b1);
        check32("sc_addr", imem_addr, 32'h80);

        // ---- reset while in WAIT; stray response in the IDLE cycle ----
        tick();
        rst_n = 1'b0;
        #1;
        check_reset("rstw");
        tick();
        tick();
        check1("stray_rvalid", imem_rvalid, 1'b1);
        rst_n = 1'b1; fix_lat = 0;
        check_reset("rstw_idle");
        tick();
        check1 ("rs_req",   imem_req,  1'b1);
        check32("rs_addr",  imem_addr, RESET_PC);
        check1 ("rs_valid", id_valid,  1'b0);
        tick();
        tick();
        check1 ("rs_valid2", id_valid, 1'b1);
        check32("rs_pc",     id_pc,    RESET_PC);
        check32("rs_ins",    id_ins,   memf(RESET_PC));

        // ---- randomized run against the program-flow model ----
        rst_n = 1'b0;
        tick(); tick();
        pend = 1'b0; imem_rvalid = 1'b0; stall = 1'b0; jmp_flag = 1'b0;
        rst_n = 1'b1; rand_lat = 1'b1;
        exp_pc = RESET_PC; ds_flag = 1'b0; tgt_m = 32'h0;
        prev_hold = 1'b0; prev_pc = 32'h0; prev_ins = 32'h0;
        n_del = 0; idle_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (prev_hold) begin
                check1 ("hold_valid", id_valid, 1'b1);
                check32("hold_pc",    id_pc,    prev_pc);
                check32("hold_ins",   id_ins,   prev_ins);
            end
            if (!id_valid) check32("empty_ins", id_ins, NOP_INS);
            stall = ($urandom_range(0, 3) == 0);
            if (id_valid && !stall) begin
                check32("rnd_pc",  id_pc,  exp_pc);
                check32("rnd_ins", id_ins, memf(exp_pc));
                check1 ("rnd_exc", if_exc, 1'b0);
                n_del++;
                idle_cnt = 0;
                if (ds_flag) begin
                    jmp_flag = 1'b0; jmp_addr = $urandom;
                    exp_pc   = tgt_m;
                    ds_flag  = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    tgt_m    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                                           : ($urandom & 32'h0000_3FFC);
                    jmp_flag = 1'b1; jmp_addr = tgt_m;
                    exp_pc   = exp_pc + 32'd4;
                    ds_flag  = 1'b1;
                end else begin
                    jmp_flag = 1'b0; jmp_addr = $urandom;
                    exp_pc   = exp_pc + 32'd4;
                end
            end else begin
                jmp_flag = 1'($urandom_range(0, 1));
                jmp_addr = $urandom;
                idle_cnt++;
                if (idle_cnt > 100) begin
                    check32("progress_timeout", 32'(idle_cnt), 32'h0);
                    break;
                end
            end
            prev_hold = id_valid && stall;
            prev_pc   = id_pc;
            prev_ins  = id_ins;
        end
        check1("enough_deliveries", n_del >= 100, 1'b1);

`ifdef IF_ALIGN_CHECK_EN
        // ---- misaligned redirect traps after the delay slot ----
        rst_n = 1'b0;
        tick(); tick();
        pend = 1'b0; imem_rvalid = 1'b0; stall = 1'b0; jmp_flag = 1'b0;
        rand_lat = 1'b0; fix_lat = 0;
        rst_n = 1'b1;
        next_valid("al0"); check32("al0_pc", id_pc, 32'h0);
        jmp_flag = 1'b1; jmp_addr = 32'h102;
        next_valid("al4");
        check32("al4_pc",  id_pc,    32'h4);
        check1 ("al4_req", imem_req, 1'b0);
        tick();
        check1 ("exc_valid", id_valid, 1'b1);
        check32("exc_ins",   id_ins,   32'h0);
        check32("exc_pc",    id_pc,    32'h102);
        check1 ("exc_flag",  if_exc,   1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check1("exc_sticky", if_exc,   1'b1);
            check1("exc_noreq",  imem_req, 1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
